ccsds123_image_arbiter: RTL and testbench

//  Shares one ccsds123_top compressor between N_SRC AXI-Stream sample sources at whole-image granularity.

---
 rtl/ccsds123_image_arbiter.sv | 127 ++++++++++++
 tb/tb_ccsds123_image_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds123_image_arbiter.sv
// Round-robin, whole-image arbiter feeding one shared CCSDS-123 compressor; zero-latency datapath.
// Backpressure passes straight through to the granted source; all others see tready=0 until the image drains.
module ccsds123_image_arbiter #(
    parameter int N_SRC     = 4,
    parameter int PIPELINES = 1,
    parameter int D         = 16,
    parameter int NX        = 4,
    parameter int NY        = 2,
    parameter int NZ        = 2
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic [N_SRC*PIPELINES*D-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]             s_axis_tvalid,
    output logic [N_SRC-1:0]             s_axis_tready,
    output logic [PIPELINES*D-1:0]       m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    input  logic                         c_tvalid,
    input  logic                         c_tready,
    input  logic                         c_tlast,
    output logic [$clog2(N_SRC)-1:0]     out_src_id,
    output logic                         busy,
    output logic [15:0]                  images_done,
    output logic                         err
);

    localparam int BEATS = (NX*NY*NZ + PIPELINES - 1) / PIPELINES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int SW    = $clog2(N_SRC);
    localparam int W     = PIPELINES * D;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t          state;
    logic [SW-1:0]   grant;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   pick;
    logic [SW-1:0]   next_ptr;
    logic [SW:0]     idx;
    logic            any_req;
    logic [CW-1:0]   cnt;
    logic            beat;
    logic            c_done;
    logic            last_beat;

    // Scan from the highest offset down so the request closest to ptr is the one left in pick.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (SW+1)'(i);
            if (idx >= (SW+1)'(N_SRC))
                idx = idx - (SW+1)'(N_SRC);
            if (s_axis_tvalid[idx[SW-1:0]]) begin
                pick    = idx[SW-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state == STREAM) begin
            m_axis_tdata         = s_axis_tdata[grant*W +: W];
            m_axis_tvalid        = s_axis_tvalid[grant];
            s_axis_tready[grant] = m_axis_tready;
        end
    end

    assign last_beat    = (cnt == CW'(BEATS - 1));
    assign m_axis_tlast = (state == STREAM) && last_beat;
    assign beat         = m_axis_tvalid & m_axis_tready;
    assign c_done       = c_tvalid & c_tready & c_tlast;
    assign next_ptr     = (grant == SW'(N_SRC - 1)) ? '0 : grant + 1'b1;
    assign out_src_id   = grant;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            images_done <= '0;
            err         <= 1'b0;
        end else begin
            // Compressor finishing an image we never fed it means its state is out of step with ours.
            if (c_done && state != DRAIN)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (c_done) begin
                        images_done <= images_done + 16'd1;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccsds123_image_arbiter.sv
// Directed bench: per-cycle comparison against an image-level arbitration model plus literal spot checks.
module tb_ccsds123_image_arbiter;

    localparam int N     = 4;
    localparam int D     = 16;
    localparam int BEATS = 16;

    logic           clk = 1'b0;
    logic           areset;
    logic [N*D-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tready;
    logic [D-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;
    logic           c_tvalid, c_tready, c_tlast;
    logic [1:0]     out_src_id;
    logic           busy;
    logic [15:0]    images_done;
    logic           err;

    ccsds123_image_arbiter #(.N_SRC(N), .PIPELINES(1), .D(D), .NX(4), .NY(2), .NZ(2)) dut (
        .clk(clk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .c_tvalid(c_tvalid), .c_tready(c_tready), .c_tlast(c_tlast),
        .out_src_id(out_src_id), .busy(busy), .images_done(images_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source and compressor emulation state
    int sent [N];
    int limit[N];
    bit bubble = 0;
    bit tmode = 0;
    int cyc = 0;
    int cd = 0;
    int drain_delay = 3;
    bit inject = 0;
    int beat_cnt = 0;
    int tlast_cnt = 0;
    int leak = 0;
    int order[$];

    // Image-level model
    bit in_use;
    int remaining;
    int cur;
    int last_served;
    int images;
    bit err_m;
    int next_out[N];

    initial for (int k = 0; k < N; k++) next_out[k] = 0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        logic ev, chs, found;
        int nxt;
        if (areset) begin
            chk("rst_tready", 32'(s_axis_tready), 32'd0);
            chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
            chk("rst_busy",   32'(busy), 32'd0);
            chk("rst_err",    32'(err), 32'd0);
            chk("rst_images", 32'(images_done), 32'd0);
            chk("rst_srcid",  32'(out_src_id), 32'd0);
            in_use = 0; remaining = 0; cur = 0; last_served = N - 1; images = 0; err_m = 0;
        end else begin
            chs = c_tvalid & c_tready & c_tlast;
            er = '0;
            ev = 1'b0;
            if (in_use && remaining > 0) begin
                er[cur] = m_axis_tready;
                ev = s_axis_tvalid[cur];
            end
            chk("tready", 32'(s_axis_tready), 32'(er));
            chk("mvalid", 32'(m_axis_tvalid), 32'(ev));
            if (ev) begin
                chk("mdata", 32'(m_axis_tdata), 32'(s_axis_tdata[cur*D +: D]));
                chk("mlast", 32'(m_axis_tlast), 32'(remaining == 1));
            end
            chk("busy",   32'(busy), 32'(in_use));
            chk("srcid",  32'(out_src_id), 32'(cur));
            chk("images", 32'(images_done), 32'(images));
            chk("err",    32'(err), 32'(err_m));

            if (!in_use) begin
                if (chs) err_m = 1;
                found = 0; nxt = 0;
                for (int j = 1; j <= N; j++) begin
                    if (!found && s_axis_tvalid[(last_served + j) % N]) begin
                        found = 1;
                        nxt = (last_served + j) % N;
                    end
                end
                if (found) begin
                    in_use = 1; cur = nxt; remaining = BEATS;
                end
            end else if (remaining > 0) begin
                if (chs) err_m = 1;
                if (s_axis_tvalid[cur] && m_axis_tready) begin
                    chk("order", 32'(m_axis_tdata), 32'(16'(cur*4096 + next_out[cur])));
                    next_out[cur]++;
                    remaining--;
                end
            end else if (chs) begin
                order.push_back(int'(out_src_id));
                images = (images + 1) % 65536;
                last_served = cur;
                in_use = 0;
            end
        end
    end

    task automatic tick();
        logic [N-1:0] hs;
        logic mbeat;
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        mbeat = m_axis_tvalid & m_axis_tready;
        if (mbeat) beat_cnt++;
        if (mbeat && m_axis_tlast) begin
            tlast_cnt++;
            cd = drain_delay;
        end
        if (s_axis_tready[1] && busy && out_src_id == 2'd0) leak++;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) sent[k]++;
            s_axis_tvalid[k] = (sent[k] < limit[k]) && !(bubble && hs[k] && (sent[k] % 2 == 1));
            s_axis_tdata[k*D +: D] = 16'(k*4096 + sent[k]);
        end
        c_tvalid = 0; c_tready = 0; c_tlast = 0;
        if (inject) begin
            c_tvalid = 1; c_tready = 1; c_tlast = 1;
            inject = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                c_tvalid = 1; c_tready = 1; c_tlast = 1;
            end
        end
        m_axis_tready = tmode ? (cyc % 3 == 0) : 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int i = 0;
        while (int'(images_done) != target && i < budget) begin
            tick();
            i++;
        end
        chk(name, 32'(images_done), 32'(target));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int base;
        int i;
        areset = 1;
        m_axis_tready = 1;
        c_tvalid = 0; c_tready = 0; c_tlast = 0;
        s_axis_tvalid = '1;
        s_axis_tdata = '0;
        for (int k = 0; k < N; k++) begin
            sent[k] = 0;
            limit[k] = 1000;
            s_axis_tdata[k*D +: D] = 16'(k*4096);
        end

        // Reset with every source requesting
        repeat (3) tick();
        chk("t1_tready", 32'(s_axis_tready), 32'd0);
        chk("t1_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t1_busy",   32'(busy), 32'd0);
        chk("t1_err",    32'(err), 32'd0);
        for (int k = 0; k < N; k++) limit[k] = 0;
        tick();
        areset = 0;

        // Lone source 2, one image
        limit[2] = 16;
        drain_delay = 3;
        wait_done(1, 100, "t2_images");
        chk("t2_srcid", 32'(out_src_id), 32'd2);
        chk("t2_sent",  32'(sent[2]), 32'd16);
        chk("t2_tlast", 32'(tlast_cnt), 32'd1);
        chk("t2_order", 32'(order.size() > 0 ? order[0] : 99), 32'd2);

        areset = 1;
        cd = 0;
        repeat (2) tick();
        areset = 0;
        chk("rst2_images", 32'(images_done), 32'd0);

        // Sources 0,1,3 contend: round robin 0,1,3,0
        order.delete();
        limit[0] = sent[0] + 32;
        limit[1] = sent[1] + 16;
        limit[3] = sent[3] + 16;
        wait_done(4, 400, "t3_images");
        chk("t3_n",  32'(order.size()), 32'd4);
        chk("t3_g0", 32'(order.size() > 0 ? order[0] : 99), 32'd0);
        chk("t3_g1", 32'(order.size() > 1 ? order[1] : 99), 32'd1);
        chk("t3_g2", 32'(order.size() > 2 ? order[2] : 99), 32'd3);
        chk("t3_g3", 32'(order.size() > 3 ? order[3] : 99), 32'd0);

        // Backpressure 1-in-3 plus source bubbles
        base = beat_cnt;
        bubble = 1;
        tmode = 1;
        limit[2] = sent[2] + 16;
        wait_done(5, 300, "t4_images");
        chk("t4_beats", 32'(beat_cnt - base), 32'd16);
        chk("t4_sent",  32'(sent[2]), 32'd32);
        bubble = 0;
        tmode = 0;

        // Long drain: src1 must stay blocked while src0's image drains
        order.delete();
        leak = 0;
        drain_delay = 200;
        limit[0] = sent[0] + 16;
        limit[1] = sent[1] + 16;
        wait_done(7, 800, "t5_images");
        chk("t5_leak", 32'(leak), 32'd0);
        chk("t5_g0", 32'(order.size() > 0 ? order[0] : 99), 32'd0);
        chk("t5_g1", 32'(order.size() > 1 ? order[1] : 99), 32'd1);

        // Stray compressor tlast during STREAM sets sticky err
        drain_delay = 3;
        limit[3] = sent[3] + 16;
        base = beat_cnt;
        i = 0;
        while (beat_cnt < base + 5 && i < 100) begin
            tick();
            i++;
        end
        chk("t6_beats", 32'(beat_cnt - base), 32'd5);
        inject = 1;
        repeat (2) tick();
        chk("t6_err",  32'(err), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        wait_done(8, 100, "t6_images");
        chk("t6_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of DRAIN
        base = tlast_cnt;
        drain_delay = 1000;
        limit[0] = sent[0] + 16;
        i = 0;
        while (tlast_cnt == base && i < 100) begin
            tick();
            i++;
        end
        chk("t7_tlast", 32'(tlast_cnt - base), 32'd1);
        repeat (3) tick();
        chk("t7_drain_busy", 32'(busy), 32'd1);
        areset = 1;
        tick();
        chk("t7_busy",   32'(busy), 32'd0);
        chk("t7_images", 32'(images_done), 32'd0);
        chk("t7_err",    32'(err), 32'd0);
        chk("t7_srcid",  32'(out_src_id), 32'd0);
        areset = 0;
        cd = 0;
        drain_delay = 3;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
